// File: rtl/bv4_inv_sched.sv
// Purpose : resource-shared GF(2^4) inverter (normal-basis tower field) serving
//           NUM_REQ requesters through one theta unit and one GF(2^2) multiplier.
// Latency : accept cycle + THETA + MUL_HI + MUL_LO, result presented in DONE.
//           The result is valid in the 4th cycle after the accept cycle, giving
//           one result every 5 cycles.
// Backpr. : DONE holds out_valid/out_data/out_id stable until out_ready.
//           in_ready stays low outside IDLE, so pending requests simply wait.
//
// Ports
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   in_valid/in_ready  : per-requester handshake; in_ready is one-hot or zero
//   in_data            : per-requester operand {Gamma_1, Gamma_0}
//   out_valid/ready    : result handshake
//   out_data, out_id   : Gamma^-1 = {Theta*Gamma_0, Theta*Gamma_1} and owner index

package bv4_pkg;
  typedef logic [1:0] bv2_t;
  typedef logic [3:0] bv4_t;

  // Norm constant of the GF(2^4)/GF(2^2) extension: Y^2 + Y + SIGMA = 0.
  // This is W^2 in the GF(2^2) normal basis {W^2, W}.
  localparam bv2_t SIGMA = 2'b10;
endpackage

// Purpose : GF(2^2) multiply, normal basis {W^2, W}, where 2'b11 is the unit.
// Latency : combinational.
// Backpr. : none.
module bv2_mul (
  input  logic [1:0] in_a,
  input  logic [1:0] in_b,
  output logic [1:0] out_y
);
  logic e;

  // The shared cross term comes from W^2*W = 1 = W^2 + W.
  assign e     = (in_a[1] ^ in_a[0]) & (in_b[1] ^ in_b[0]);
  assign out_y = {(in_a[1] & in_b[1]) ^ e, (in_a[0] & in_b[0]) ^ e};
endmodule

// Purpose : Theta = (G1*G0 + (G1+G0)^2 * SIGMA)^-1 over GF(2^2).
// Latency : combinational.
// Backpr. : none.
module bv4_comp_theta (
  input  logic [3:0] in_g,
  output logic [1:0] out_th
);
  import bv4_pkg::*;

  bv2_t g1, g0, sum, sum_sq, prod, scaled, d;

  assign g1     = in_g[3:2];
  assign g0     = in_g[1:0];
  assign sum    = g1 ^ g0;
  // Squaring in a normal basis is a coordinate swap.
  assign sum_sq = {sum[0], sum[1]};

  bv2_mul u_prod  (.in_a(g1),     .in_b(g0),    .out_y(prod));
  bv2_mul u_scale (.in_a(sum_sq), .in_b(SIGMA), .out_y(scaled));

  assign d      = prod ^ scaled;
  // In GF(4), x^-1 = x^2, which is again a swap. Zero maps to zero.
  assign out_th = {d[0], d[1]};
endmodule

// Purpose : round-robin scheduler around the shared theta/multiply datapath.
// Latency : 4 cycles from the accept cycle to out_valid, 5-cycle throughput.
// Backpr. : out_ready low parks the FSM in DONE; in_ready is low outside IDLE.
module bv4_inv_sched #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_REQ-1:0]           in_valid,
  output logic [NUM_REQ-1:0]           in_ready,
  input  bv4_pkg::bv4_t [NUM_REQ-1:0]  in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output bv4_pkg::bv4_t                out_data,
  output logic [ID_W-1:0]              out_id
);
  import bv4_pkg::*;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    THETA  = 3'd1,
    MUL_HI = 3'd2,
    MUL_LO = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   id_q, id_d;
  bv4_t              op_q, op_d;
  bv2_t              th_q, th_d;
  bv4_t              res_q, res_d;

  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_id;
  logic [NUM_REQ-1:0] gnt_oh;
  bv4_t              gnt_dat;

  bv2_t              theta_w;
  bv2_t              mul_b;
  bv2_t              mul_y;

  // ------------------------------------------------------------------
  // Round-robin pick: the lowest valid index >= rr_q wins, otherwise the
  // lowest valid index below rr_q (the wrap-around part of the search).
  // ------------------------------------------------------------------
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && in_valid[i] && (ID_W'(i) >= rr_q)) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_vld && in_valid[i] && (ID_W'(i) < rr_q)) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(i);
      end
    end
  end

  // Decode the winner into a one-hot ready vector and select its operand.
  always_comb begin
    gnt_oh  = '0;
    gnt_dat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        gnt_oh[i] = gnt_vld;
        gnt_dat   = in_data[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Shared arithmetic. Theta always sees the latched operand. The single
  // multiplier's second operand is steered by state, and it is held at
  // zero when unused so the multiplier stays quiet.
  // ------------------------------------------------------------------
  bv4_comp_theta u_theta (
    .in_g   (op_q),
    .out_th (theta_w)
  );

  assign mul_b = (state_q == MUL_HI) ? op_q[1:0] :
                 (state_q == MUL_LO) ? op_q[3:2] : 2'b00;

  bv2_mul u_mul (
    .in_a  (th_q),
    .in_b  (mul_b),
    .out_y (mul_y)
  );

  // ------------------------------------------------------------------
  // Next-state and output logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    id_d      = id_q;
    op_d      = op_q;
    th_d      = th_q;
    res_d     = res_q;
    in_ready  = '0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          in_ready = gnt_oh;
          op_d     = gnt_dat;
          id_d     = gnt_id;
          state_d  = THETA;
        end
      end
      THETA: begin
        th_d    = theta_w;
        state_d = MUL_HI;
      end
      MUL_HI: begin
        res_d[3:2] = mul_y;   // Theta * Gamma_0
        state_d    = MUL_LO;
      end
      MUL_LO: begin
        res_d[1:0] = mul_y;   // Theta * Gamma_1
        state_d    = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          rr_d    = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset is synchronous, so suppress both handshakes while it is held.
    // This keeps a grant from being advertised in a cycle that gets discarded.
    if (!rst_ni) begin
      in_ready  = '0;
      out_valid = 1'b0;
    end
  end

  assign out_data = res_q;
  assign out_id   = id_q;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      op_q    <= '0;
      th_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      th_q    <= th_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_bv4_inv_sched.sv
// Directed bench for bv4_inv_sched (NUM_REQ = 2). Expected inverses come from a
// hand-derived table for the normal-basis tower field in which 4'hF is the unit.
module tb_bv4_inv_sched;

  logic            clk;
  logic            rst_n;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0][3:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_data;
  logic [0:0]      out_id;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int both_hi = 0;

  logic [3:0] inv_tab [0:15];

  bv4_inv_sched #(.NUM_REQ(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (in_ready == 2'b11) both_hi <= both_hi + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // GF(2^2) and GF(2^4) products, used only for the x * x^-1 == 1 property.
  function automatic logic [1:0] m4(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] e;
    e = m4(2'b10, m4(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {m4(a[3:2], b[3:2]) ^ e, m4(a[1:0], b[1:0]) ^ e};
  endfunction

  // Raise a request in the next cycle and check that it is granted at once.
  task automatic present(input logic req, input logic [3:0] d, output int acc);
    @(negedge clk);
    in_valid[req] = 1'b1;
    in_data[req]  = d;
    #1;
    chk("accept_ready", 32'(in_ready), req ? 32'd2 : 32'd1);
    acc = cyc;
  endtask

  // Follow an accepted request to its result. The operand is scrambled after
  // acceptance to show that the latched copy is what gets used.
  task automatic finish(input logic req, input logic [3:0] d,
                        input logic [3:0] exp_d, input logic exp_id);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        in_valid[req] = 1'b0;
        in_data[req]  = ~d;
      end
    end while (!out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd4);
    chk("out_data", 32'(out_data), 32'(exp_d));
    chk("out_id", 32'(out_id), 32'(exp_id));
  endtask

  initial begin
    int acc;
    int prev;
    int lat;
    int w;
    logic [3:0] xv;

    inv_tab = '{4'h0, 4'hC, 4'h8, 4'h4, 4'h3, 4'hA, 4'h7, 4'h6,
                4'h2, 4'hD, 4'h5, 4'hE, 4'h1, 4'h9, 4'hB, 4'hF};

    // Reset with requests pending: nothing may be granted.
    rst_n     = 1'b0;
    in_valid  = 2'b11;
    in_data   = {4'hF, 4'hF};
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    rst_n    = 1'b1;
    in_valid = 2'b00;

    // Field unit from requester 0.
    present(1'b0, 4'hF, acc);
    finish(1'b0, 4'hF, 4'hF, 1'b0);
    prev = acc;

    // All 16 operands back to back from requester 0.
    for (int x = 0; x < 16; x++) begin
      xv = 4'(x);
      present(1'b0, xv, acc);
      chk("period", 32'(acc - prev), 32'd5);
      prev = acc;
      finish(1'b0, xv, inv_tab[xv], 1'b0);
      if (xv != 4'h0) chk("x_times_inv", 32'(m16(xv, out_data)), 32'hF);
    end

    // Zero operand from requester 1. This also brings the pointer back to 0.
    present(1'b1, 4'h0, acc);
    finish(1'b1, 4'h0, 4'h0, 1'b1);

    // Contention: both held valid, grants must alternate 0,1,0,1.
    @(negedge clk);
    in_data[0] = 4'h3;
    in_data[1] = 4'hC;
    in_valid   = 2'b11;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      #1;
      while (in_ready == 2'b00 && w < 20) begin
        @(negedge clk);
        #1;
        w++;
      end
      chk("ctn_grant", 32'(in_ready), 32'(t % 2 + 1));
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 20);
      chk("ctn_latency", 32'(lat), 32'd4);
      chk("ctn_out_id", 32'(out_id), 32'(t % 2));
      chk("ctn_out_data", 32'(out_data), (t % 2 == 1) ? 32'h1 : 32'h4);
      @(negedge clk);
    end
    in_valid = 2'b00;
    chk("ready_onehot", 32'(both_hi), 32'd0);

    // Backpressure: requester 1 result is held for 10 cycles while requester 0 waits.
    out_ready = 1'b0;
    present(1'b1, 4'h9, acc);
    @(negedge clk);
    in_valid[1] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 4'h2;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({out_valid, out_data, out_id, in_ready}),
          32'({1'b1, 4'hD, 1'b1, 2'b00}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_released", 32'(out_valid), 32'd0);
    chk("bp_waiter_grant", 32'(in_ready), 32'd1);
    finish(1'b0, 4'h2, 4'h8, 1'b0);

    // Reset in MUL_HI: the transaction is dropped and the pointer returns to 0.
    present(1'b0, 4'h7, acc);
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b0;
    in_valid   = 2'b11;
    in_data[1] = 4'hA;
    @(negedge clk);
    #1;
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    @(negedge clk);
    chk("mrst_out_valid2", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mrst_grant_rr0", 32'(in_ready), 32'd1);
    finish(1'b0, 4'h7, 4'h6, 1'b0);
    @(negedge clk);
    #1;
    chk("mrst_next_grant", 32'(in_ready), 32'd2);
    finish(1'b1, 4'hA, 4'h5, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
